// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB LED PWM driver.
package rgb_pkg;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

    localparam rgb_t RGB_OFF   = 3'b000;
    localparam rgb_t RGB_RED   = 3'b100;
    localparam rgb_t RGB_GREEN = 3'b010;
    localparam rgb_t RGB_BLUE  = 3'b001;
    localparam rgb_t RGB_WHITE = 3'b111;

    typedef enum logic {
        BLINK_ON  = 1'b0,
        BLINK_OFF = 1'b1
    } blink_state_e;

    // Blank a colour when the LED is in its off phase.
    function automatic rgb_t rgb_gate(input rgb_t colour, input logic on);
        rgb_t res;
        if (on) begin
            res = colour;
        end else begin
            res = RGB_OFF;
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler: divides clk by PRESC and emits a one-clk tick on the last count.
module pwm_tick_gen #(
    parameter int PRESC = 100
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

    logic [PW-1:0] presc_cnt_r;

    assign tick = (presc_cnt_r == PRESC_LAST);

    // Prescaler counter, wrapping to zero on tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_cnt_r <= '0;
        end else if (tick) begin
            presc_cnt_r <= '0;
        end else begin
            presc_cnt_r <= presc_cnt_r + PW'(1);
        end
    end

endmodule

// File: rtl/rgb_led_pwm_driver.sv
// RGB LED driver: period-aligned colour/brightness latching, PWM dimming and
// optional blinking, with registered LED outputs.
module rgb_led_pwm_driver
    import rgb_pkg::*;
#(
    parameter int PRESC         = 100,
    parameter int PWM_BITS      = 4,
    parameter int BLINK_PERIODS = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                r_in,
    input  logic                g_in,
    input  logic                b_in,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic                blink_en,
    output logic                led_r,
    output logic                led_g,
    output logic                led_b,
    output logic                period_start
);

    localparam int BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIODS - 1);

    logic                tick_s;
    logic                period_end_s;
    logic                on_s;
    rgb_t                led_s;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    rgb_t                colour_lat_r;
    logic [PWM_BITS-1:0] bright_lat_r;
    blink_state_e        blink_state_r;
    blink_state_e        blink_state_s;
    logic [BW-1:0]       blink_cnt_r;
    logic [BW-1:0]       blink_cnt_s;

    pwm_tick_gen #(
        .PRESC (PRESC)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

    assign period_end_s = tick_s && (pwm_cnt_r == {PWM_BITS{1'b1}});

    // Duty decision and colour gating for the current counter state.
    always_comb begin
        on_s  = (pwm_cnt_r < bright_lat_r) && (blink_state_r == BLINK_ON);
        led_s = rgb_gate(colour_lat_r, on_s);
    end

    // Blink next-state: disabling forces ON, otherwise toggle every BLINK_PERIODS ends.
    always_comb begin
        blink_state_s = blink_state_r;
        blink_cnt_s   = blink_cnt_r;
        if (!blink_en) begin
            blink_state_s = BLINK_ON;
            blink_cnt_s   = '0;
        end else if (period_end_s) begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_s = '0;
                case (blink_state_r)
                    BLINK_ON:  blink_state_s = BLINK_OFF;
                    BLINK_OFF: blink_state_s = BLINK_ON;
                    default:   blink_state_s = BLINK_ON;
                endcase
            end else begin
                blink_cnt_s = blink_cnt_r + BW'(1);
            end
        end else begin
            blink_cnt_s = blink_cnt_r;
        end
    end

    // Blink state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_state_r <= BLINK_ON;
            blink_cnt_r   <= '0;
        end else begin
            blink_state_r <= blink_state_s;
            blink_cnt_r   <= blink_cnt_s;
        end
    end

    // PWM counter, period-boundary latches and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_r    <= '0;
            colour_lat_r <= RGB_OFF;
            bright_lat_r <= '0;
            period_start <= 1'b0;
            led_r        <= 1'b0;
            led_g        <= 1'b0;
            led_b        <= 1'b0;
        end else begin
            if (tick_s) begin
                pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
            end
            if (period_end_s) begin
                colour_lat_r <= '{r: r_in, g: g_in, b: b_in};
                bright_lat_r <= brightness;
            end
            period_start <= period_end_s;
            led_r        <= led_s.r;
            led_g        <= led_s.g;
            led_b        <= led_s.b;
        end
    end

endmodule
